mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed (32-bit data/address, 5-bit register index).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 AluRes_i  in  32  EX/MEM ALU result; memory byte address for loads/stores.
REQ-005 Op2_i  in  32  EX/MEM store data.
REQ-006 PC_i  in  32  EX/MEM instruction PC.
REQ-007 MemWr_i, MemRd_i  in  1 each  store / load request.
REQ-008 MemtoReg_i  in  2  writeback select.
REQ-009 RegWr_i  in  1  register write enable.
REQ-010 Rf_i  in  5  destination register index.
REQ-011 Ins_i  in  32  instruction word.
REQ-012 mem_req, mem_we  out  1 each  data-memory request / write strobe.
REQ-013 mem_addr, mem_wdata  out  32 each  word address / write data.
REQ-014 mem_rdata  in  32; mem_ack  in  1  read data / access complete.
REQ-015 stall_o  out  1  holds upstream EX/MEM register and earlier stages.
REQ-016 WbData_o  out  32; Rf_o  out  5; RegWr_o  out  1; Ins_o  out  32  MEM/WB register.
REQ-017 MisAlign_o  out  1  one-cycle pulse: misaligned access dropped.

Function
REQ-018 FSM states IDLE, ACCESS; reset state IDLE.
REQ-019 Memory op = MemRd_i | MemWr_i; with both high, treat as store (MemWr_i priority).
REQ-020 IDLE, no memory op: stall_o=0; next edge loads MEM/WB from inputs (1-cycle latency).
REQ-021 IDLE, memory op, AluRes_i[1:0]==00: stall_o=1 combinationally; next edge -> ACCESS; MEM/WB loads a bubble.
REQ-022 IDLE, memory op, AluRes_i[1:0]!=00: no access, stall_o=0; next edge MEM/WB loads the instruction with RegWr_o=0 and MisAlign_o=1 for one cycle.
REQ-023 ACCESS: mem_req=1; mem_we=1 for store, 0 for load; mem_addr={AluRes_i[31:2],2'b00}; mem_wdata=Op2_i; inputs stay stable because upstream is stalled.
REQ-024 ACCESS, mem_ack=0: stall_o=1; remain; MEM/WB loads a bubble each edge.
REQ-025 ACCESS, mem_ack=1: stall_o=0 in that cycle; next edge -> IDLE, MEM/WB loads the instruction (mem_rdata captured for loads), and upstream advances on the same edge.
REQ-026 mem_req, mem_we SHALL be 0 in IDLE; mem_ack in IDLE SHALL be ignored.
REQ-027 Bubble: RegWr_o=0, Rf_o=0, Ins_o=0, WbData_o=0.
REQ-028 WbData select: 00 AluRes_i; 01 mem_rdata (loads only, else AluRes_i); 10 PC_i+4 modulo 2^32; 11 AluRes_i.
REQ-029 Rf_o, RegWr_o, Ins_o SHALL carry Rf_i, RegWr_i, Ins_i unchanged on non-bubble loads.
REQ-030 Back-to-back memory ops: after the completing edge, the next op begins in IDLE per REQ-021; there is no zero-cycle gap.

Reset
REQ-031 Reset asserted: state=IDLE; mem_req=0, mem_we=0; WbData_o=0, Rf_o=0, RegWr_o=0, Ins_o=0, MisAlign_o=0.
REQ-032 Reset during ACCESS: abort immediately, mem_req drops asynchronously, and no MEM/WB load of the pending instruction occurs.
REQ-033 After release, first rising edge behaves as IDLE per REQ-020..022.

Verification
REQ-034 ALU op: AluRes_i=0x1234, MemtoReg_i=00, RegWr_i=1, Rf_i=5 -> next edge WbData_o=0x1234, Rf_o=5, RegWr_o=1, stall_o=0 throughout.
REQ-035 Load with 2-cycle ack delay: AluRes_i=0x100, mem_rdata=0xDEADBEEF -> stall_o=1 for 3 cycles, mem_addr=0x100, mem_we=0; after ack, WbData_o=0xDEADBEEF; bubbles during stall.
REQ-036 Store: AluRes_i=0x204, Op2_i=0xCAFE, MemWr_i=MemRd_i=1, ack same cycle -> one ACCESS cycle, mem_we=1, mem_wdata=0xCAFE, stall_o high 1 cycle.
REQ-037 Misaligned load: AluRes_i=0x102 -> no mem_req, MisAlign_o pulses once, RegWr_o=0, stall_o=0.
REQ-038 JAL writeback: MemtoReg_i=10, PC_i=0xFFFFFFFC -> WbData_o=0x00000000 (wrap).
REQ-039 Reset asserted mid-ACCESS -> mem_req=0 immediately, all outputs 0, state IDLE; a subsequent ALU op completes in 1 cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register.
// Aligned loads and stores take a two-state handshake (IDLE -> ACCESS) with
// the data memory. The upstream pipeline is held via stall_o until mem_ack
// arrives. Misaligned accesses are dropped and flagged with MisAlign_o.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   AluRes_i/Op2_i/PC_i         EX/MEM ALU result (byte address), store data, PC
//   MemWr_i/MemRd_i             store / load request (store wins if both set)
//   MemtoReg_i, RegWr_i, Rf_i   writeback select, write enable, dest register
//   Ins_i                       instruction word
//   mem_req/mem_we/mem_addr/mem_wdata   data-memory request side
//   mem_rdata/mem_ack           data-memory response side
//   stall_o                     holds EX/MEM and earlier stages
//   WbData_o/Rf_o/RegWr_o/Ins_o MEM/WB register
//   MisAlign_o                  one-cycle pulse for a dropped misaligned access
module mem_wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] AluRes_i,
  input  logic [31:0] Op2_i,
  input  logic [31:0] PC_i,
  input  logic        MemWr_i,
  input  logic        MemRd_i,
  input  logic [1:0]  MemtoReg_i,
  input  logic        RegWr_i,
  input  logic [4:0]  Rf_i,
  input  logic [31:0] Ins_i,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_o,
  output logic [31:0] WbData_o,
  output logic [4:0]  Rf_o,
  output logic        RegWr_o,
  output logic [31:0] Ins_o,
  output logic        MisAlign_o
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic        mem_op;
  logic        is_load;
  logic        aligned;
  logic        load_instr;
  logic        regwr_nxt;
  logic        mis_nxt;
  logic [31:0] wb_sel;

  assign mem_op  = MemRd_i | MemWr_i;
  assign is_load = MemRd_i & ~MemWr_i;
  assign aligned = (AluRes_i[1:0] == 2'b00);

  // Read data is only meaningful on the completing ACCESS cycle of a load.
  always_comb begin
    wb_sel = AluRes_i;
    case (MemtoReg_i)
      2'b01:   wb_sel = (state == ACCESS && is_load) ? mem_rdata : AluRes_i;
      2'b10:   wb_sel = PC_i + 32'd4;
      default: wb_sel = AluRes_i;
    endcase
  end

  always_comb begin
    state_nxt  = state;
    stall_o    = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {AluRes_i[31:2], 2'b00};
    mem_wdata  = Op2_i;
    load_instr = 1'b0;
    regwr_nxt  = RegWr_i;
    mis_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && aligned) begin
          stall_o   = 1'b1;
          state_nxt = ACCESS;
        end else if (mem_op) begin
          // Dropped access: instruction retires but must not write back.
          load_instr = 1'b1;
          regwr_nxt  = 1'b0;
          mis_nxt    = 1'b1;
        end else begin
          load_instr = 1'b1;
        end
      end
      ACCESS: begin
        mem_req = 1'b1;
        mem_we  = MemWr_i;
        if (mem_ack) begin
          state_nxt  = IDLE;
          load_instr = 1'b1;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      WbData_o   <= '0;
      Rf_o       <= '0;
      RegWr_o    <= 1'b0;
      Ins_o      <= '0;
      MisAlign_o <= 1'b0;
    end else begin
      state      <= state_nxt;
      MisAlign_o <= mis_nxt;
      if (load_instr) begin
        WbData_o <= wb_sel;
        Rf_o     <= Rf_i;
        RegWr_o  <= regwr_nxt;
        Ins_o    <= Ins_i;
      end else begin
        WbData_o <= '0;
        Rf_o     <= '0;
        RegWr_o  <= 1'b0;
        Ins_o    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk, reset;
  logic [31:0] AluRes_i, Op2_i, PC_i, Ins_i, mem_rdata;
  logic        MemWr_i, MemRd_i, RegWr_i, mem_ack;
  logic [1:0]  MemtoReg_i;
  logic [4:0]  Rf_i;
  logic        mem_req, mem_we, stall_o, RegWr_o, MisAlign_o;
  logic [31:0] mem_addr, mem_wdata, WbData_o, Ins_o;
  logic [4:0]  Rf_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  mem_wb_stage dut (
    .clk(clk), .reset(reset),
    .AluRes_i(AluRes_i), .Op2_i(Op2_i), .PC_i(PC_i),
    .MemWr_i(MemWr_i), .MemRd_i(MemRd_i), .MemtoReg_i(MemtoReg_i),
    .RegWr_i(RegWr_i), .Rf_i(Rf_i), .Ins_i(Ins_i),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_o(stall_o),
    .WbData_o(WbData_o), .Rf_o(Rf_o), .RegWr_o(RegWr_o), .Ins_o(Ins_o),
    .MisAlign_o(MisAlign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [31:0] alu, input logic [31:0] op2, input logic [31:0] pc,
                        input logic wr, input logic rd, input logic [1:0] mtr,
                        input logic rw, input logic [4:0] rf, input logic [31:0] ins);
    AluRes_i = alu; Op2_i = op2; PC_i = pc; MemWr_i = wr; MemRd_i = rd;
    MemtoReg_i = mtr; RegWr_i = rw; Rf_i = rf; Ins_i = ins;
  endtask

  task automatic chk_bubble(input string name);
    chk({name, ".wb"},    WbData_o, 32'h0);
    chk({name, ".rf"},    {27'h0, Rf_o}, 32'h0);
    chk({name, ".regwr"}, {31'h0, RegWr_o}, 32'h0);
    chk({name, ".ins"},   Ins_o, 32'h0);
  endtask

  typedef struct {
    string       name;
    logic [31:0] alu, pc, ins;
    logic        wr, rd, rw, ack;
    logic [1:0]  mtr;
    logic [4:0]  rf;
    logic        e_stall, e_regwr, e_mis;
    logic [31:0] e_wb;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // name, alu, pc, ins, wr, rd, rw, ack, mtr, rf, e_stall, e_regwr, e_mis, e_wb
    vecs[0] = '{"alu_op",    32'h1234, 32'h0,        32'h00A00293, 0,0,1,1, 2'b00, 5'd5,  0,1,0, 32'h1234};
    vecs[1] = '{"jal_wrap",  32'h55,   32'hFFFFFFFC, 32'h0000006F, 0,0,1,0, 2'b10, 5'd1,  0,1,0, 32'h0};
    vecs[2] = '{"jal_pc4",   32'h55,   32'h1000,     32'h008000EF, 0,0,1,0, 2'b10, 5'd1,  0,1,0, 32'h1004};
    vecs[3] = '{"mtr01_alu", 32'h77,   32'h0,        32'h11111111, 0,0,1,1, 2'b01, 5'd3,  0,1,0, 32'h77};
    vecs[4] = '{"mtr11_alu", 32'hABCD, 32'h0,        32'h22222222, 0,0,0,0, 2'b11, 5'd31, 0,0,0, 32'hABCD};
    vecs[5] = '{"misal_ld",  32'h102,  32'h0,        32'h10202383, 0,1,1,0, 2'b01, 5'd7,  0,0,1, 32'h102};
    vecs[6] = '{"misal_st",  32'h203,  32'h0,        32'h20302023, 1,0,0,1, 2'b00, 5'd0,  0,0,1, 32'h203};
    vecs[7] = '{"post_mis",  32'h9,    32'h0,        32'h33333333, 0,0,1,0, 2'b00, 5'd12, 0,1,0, 32'h9};
  end

  initial begin
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
    set_in(32'h0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 5'd0, 32'h0);
    #1;
    chk_bubble("reset");
    chk("reset.mis", {31'h0, MisAlign_o}, 32'h0);
    chk("reset.req", {31'h0, mem_req}, 32'h0);
    chk("reset.we",  {31'h0, mem_we}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Single-cycle IDLE behaviour; mem_ack is toggled in some rows to show it is ignored.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_in(vecs[i].alu, 32'hF00D, vecs[i].pc, vecs[i].wr, vecs[i].rd, vecs[i].mtr,
             vecs[i].rw, vecs[i].rf, vecs[i].ins);
      mem_ack = vecs[i].ack;
      #1;
      chk({vecs[i].name, ".stall"}, {31'h0, stall_o}, {31'h0, vecs[i].e_stall});
      chk({vecs[i].name, ".req"},   {31'h0, mem_req}, 32'h0);
      @(posedge clk); #1;
      chk({vecs[i].name, ".wb"},    WbData_o, vecs[i].e_wb);
      chk({vecs[i].name, ".rf"},    {27'h0, Rf_o}, {27'h0, vecs[i].rf});
      chk({vecs[i].name, ".regwr"}, {31'h0, RegWr_o}, {31'h0, vecs[i].e_regwr});
      chk({vecs[i].name, ".ins"},   Ins_o, vecs[i].ins);
      chk({vecs[i].name, ".mis"},   {31'h0, MisAlign_o}, {31'h0, vecs[i].e_mis});
      chk({vecs[i].name, ".req_after"}, {31'h0, mem_req}, 32'h0);
    end
    mem_ack = 1'b0;

    // Load with ack two cycles into ACCESS: three stalled cycles.
    @(negedge clk);
    set_in(32'h100, 32'h0, 32'h40, 0, 1, 2'b01, 1, 5'd9, 32'h10002483);
    mem_rdata = 32'hDEADBEEF;
    #1;
    chk("ld.stall0", {31'h0, stall_o}, 32'h1);
    chk("ld.req0",   {31'h0, mem_req}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk_bubble("ld.wait");
      chk("ld.req",   {31'h0, mem_req}, 32'h1);
      chk("ld.we",    {31'h0, mem_we}, 32'h0);
      chk("ld.addr",  mem_addr, 32'h100);
      chk("ld.stall", {31'h0, stall_o}, 32'h1);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk("ld.stall_ack", {31'h0, stall_o}, 32'h0);
    chk("ld.req_ack",   {31'h0, mem_req}, 32'h1);
    @(posedge clk); #1;
    chk("ld.wb",    WbData_o, 32'hDEADBEEF);
    chk("ld.rf",    {27'h0, Rf_o}, 32'd9);
    chk("ld.regwr", {31'h0, RegWr_o}, 32'h1);
    chk("ld.ins",   Ins_o, 32'h10002483);
    chk("ld.req_done", {31'h0, mem_req}, 32'h0);

    // Back-to-back store (both strobes high => store), ack already high in IDLE.
    @(negedge clk);
    set_in(32'h204, 32'hCAFE, 32'h44, 1, 1, 2'b00, 0, 5'd0, 32'h00F02223);
    #1;
    chk("st.stall0", {31'h0, stall_o}, 32'h1);
    chk("st.req0",   {31'h0, mem_req}, 32'h0);
    @(posedge clk); #1;
    chk_bubble("st.acc");
    chk("st.req",   {31'h0, mem_req}, 32'h1);
    chk("st.we",    {31'h0, mem_we}, 32'h1);
    chk("st.wdata", mem_wdata, 32'hCAFE);
    chk("st.addr",  mem_addr, 32'h204);
    chk("st.stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    chk("st.wb",    WbData_o, 32'h204);
    chk("st.regwr", {31'h0, RegWr_o}, 32'h0);
    chk("st.ins",   Ins_o, 32'h00F02223);
    chk("st.req_done", {31'h0, mem_req}, 32'h0);
    mem_ack = 1'b0;

    // Reset clears a non-bubble MEM/WB value immediately.
    @(negedge clk);
    set_in(32'h77AA, 32'h0, 32'h0, 0, 0, 2'b00, 1, 5'd4, 32'h44444444);
    @(posedge clk); #1;
    chk("pre_rst.wb", WbData_o, 32'h77AA);
    #2 reset = 1'b1;
    #1;
    chk_bubble("rst_async");
    reset = 1'b0;

    // Reset during ACCESS: request drops at once, pending load never retires.
    @(negedge clk);
    set_in(32'h500, 32'h0, 32'h0, 0, 1, 2'b01, 1, 5'd6, 32'h50003303);
    @(posedge clk); #1;
    chk("rst_acc.req_before", {31'h0, mem_req}, 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("rst_acc.req", {31'h0, mem_req}, 32'h0);
    chk("rst_acc.we",  {31'h0, mem_we}, 32'h0);
    chk_bubble("rst_acc");
    chk("rst_acc.mis", {31'h0, MisAlign_o}, 32'h0);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    chk("rst_acc.hold_wb", WbData_o, 32'h0);
    chk("rst_acc.hold_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b0;
    set_in(32'h1234, 32'h0, 32'h0, 0, 0, 2'b00, 1, 5'd5, 32'h66666666);
    #1;
    chk("post_rst.stall", {31'h0, stall_o}, 32'h0);
    @(posedge clk); #1;
    chk("post_rst.wb",    WbData_o, 32'h1234);
    chk("post_rst.rf",    {27'h0, Rf_o}, 32'd5);
    chk("post_rst.regwr", {31'h0, RegWr_o}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
